// File: rtl/mbox_mem_arb.sv
// Two-port arbiter and cycle sequencer for the MBOX single-ported synchronous memory.
// Shares the memory between the EBOX and the front end, with PSE locking and front-end anti-starvation.
module mbox_mem_arb #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 36,
  parameter int STARVE_MAX = 4
) (
  input  logic              mboxClk,
  input  logic              mboxRstN,
  input  logic              ebReq,
  input  logic              ebRead,
  input  logic              ebWrite,
  input  logic              ebPSE,
  input  logic [ADDR_W-1:0] ebAddr,
  input  logic [DATA_W-1:0] ebWData,
  output logic              ebAck,
  output logic [DATA_W-1:0] ebRData,
  output logic              ebRValid,
  input  logic              feReq,
  input  logic              feRead,
  input  logic              feWrite,
  input  logic              fePSE,
  input  logic [ADDR_W-1:0] feAddr,
  input  logic [DATA_W-1:0] feWData,
  output logic              feAck,
  output logic [DATA_W-1:0] feRData,
  output logic              feRValid,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  output logic              memWe,
  input  logic [DATA_W-1:0] memDout,
  output logic              lockValid,
  output logic              lockOwner,
  output logic              busy,
  output logic              protoErr,
  output logic [1:0]        dbgState,
  output logic [3:0]        dbgStarveCnt
);

  // Handshake: a requester raises req with its qualifiers and holds all of them
  // stable until it sees the one-cycle ack; only then may it drop or change them.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_starve;
  logic        r_rd;
  logic        r_port_fe;

  logic              w_eb_legal, w_fe_legal, w_eb_elig, w_fe_elig;
  logic              w_gnt_eb, w_gnt_fe, w_gnt;
  logic              w_gnt_rd, w_gnt_pse;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_wdata;
  logic              w_illegal;

  always_comb begin
    w_eb_legal  = ebReq && (ebRead ^ ebWrite);
    w_fe_legal  = feReq && (feRead ^ feWrite);
    w_eb_elig   = w_eb_legal && (!lockValid || !lockOwner);
    w_fe_elig   = w_fe_legal && (!lockValid || lockOwner);
    // FE wins when EBOX is absent/blocked or when FE has been passed over too often
    w_gnt_fe    = (r_state == S_IDLE) && w_fe_elig && (!w_eb_elig || (r_starve == LP_STARVE_MAX));
    w_gnt_eb    = (r_state == S_IDLE) && w_eb_elig && !w_gnt_fe;
    w_gnt       = w_gnt_eb || w_gnt_fe;
    w_gnt_rd    = w_gnt_fe ? feRead  : ebRead;
    w_gnt_pse   = w_gnt_fe ? fePSE   : ebPSE;
    w_gnt_addr  = w_gnt_fe ? feAddr  : ebAddr;
    w_gnt_wdata = w_gnt_fe ? feWData : ebWData;
    w_illegal   = (ebReq && (ebRead == ebWrite)) || (feReq && (feRead == feWrite));
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = r_rd ? S_RDATA : S_IDLE;
      S_RDATA: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge mboxClk or negedge mboxRstN) begin
    if (!mboxRstN) begin
      r_state   <= S_IDLE;
      r_starve  <= 4'd0;
      r_rd      <= 1'b0;
      r_port_fe <= 1'b0;
      ebAck     <= 1'b0;
      feAck     <= 1'b0;
      ebRValid  <= 1'b0;
      feRValid  <= 1'b0;
      ebRData   <= '0;
      feRData   <= '0;
      memAddr   <= '0;
      memDin    <= '0;
      memWe     <= 1'b0;
      lockValid <= 1'b0;
      lockOwner <= 1'b0;
      protoErr  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      ebAck    <= w_gnt_eb;
      feAck    <= w_gnt_fe;
      ebRValid <= 1'b0;
      feRValid <= 1'b0;
      memWe    <= 1'b0;
      if (w_illegal) protoErr <= 1'b0 | 1'b1;
      if (w_gnt) begin
        memAddr   <= w_gnt_addr;
        memDin    <= w_gnt_rd ? '0 : w_gnt_wdata;
        memWe     <= !w_gnt_rd;
        r_rd      <= w_gnt_rd;
        r_port_fe <= w_gnt_fe;
        if (w_gnt_rd && w_gnt_pse) begin
          lockValid <= 1'b1;
          lockOwner <= w_gnt_fe;
        end else if (!w_gnt_rd && lockValid) begin
          // only the owner can be granted while locked, so any granted write unlocks
          lockValid <= 1'b0;
        end
      end
      if (r_state == S_RDATA) begin
        if (r_port_fe) begin
          feRData  <= memDout;
          feRValid <= 1'b1;
        end else begin
          ebRData  <= memDout;
          ebRValid <= 1'b1;
        end
      end
      if (r_state == S_IDLE) begin
        if (w_gnt_fe || !feReq) begin
          r_starve <= 4'd0;
        end else if (w_gnt_eb && w_fe_legal && (r_starve != LP_STARVE_MAX)) begin
          // saturates: a lock can keep FE out past the starvation limit
          r_starve <= r_starve + 4'd1;
        end
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign dbgState     = r_state;
  assign dbgStarveCnt = r_starve;

endmodule

// File: tb/tb_mbox_mem_arb.sv
// Randomized + directed bench for mbox_mem_arb, checked every cycle against a
// transaction-level reference model (occupancy countdowns, shadow memory, lock/starve rules).
module tb_mbox_mem_arb;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 36;
  localparam int STARVE_MAX = 4;

  typedef struct {
    logic              rd;
    logic              wr;
    logic              pse;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                gap;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ebReq = 1'b0, ebRead = 1'b0, ebWrite = 1'b0, ebPSE = 1'b0;
  logic feReq = 1'b0, feRead = 1'b0, feWrite = 1'b0, fePSE = 1'b0;
  logic [ADDR_W-1:0] ebAddr = '0, feAddr = '0;
  logic [DATA_W-1:0] ebWData = '0, feWData = '0;
  logic ebAck, ebRValid, feAck, feRValid, memWe, lockValid, lockOwner, busy, protoErr;
  logic [DATA_W-1:0] ebRData, feRData, memDin;
  logic [DATA_W-1:0] memDout = '0;
  logic [ADDR_W-1:0] memAddr;
  logic [1:0] dbgState;
  logic [3:0] dbgStarveCnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  mbox_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .mboxClk(clk), .mboxRstN(rst_n),
    .ebReq(ebReq), .ebRead(ebRead), .ebWrite(ebWrite), .ebPSE(ebPSE),
    .ebAddr(ebAddr), .ebWData(ebWData), .ebAck(ebAck), .ebRData(ebRData), .ebRValid(ebRValid),
    .feReq(feReq), .feRead(feRead), .feWrite(feWrite), .fePSE(fePSE),
    .feAddr(feAddr), .feWData(feWData), .feAck(feAck), .feRData(feRData), .feRValid(feRValid),
    .memAddr(memAddr), .memDin(memDin), .memWe(memWe), .memDout(memDout),
    .lockValid(lockValid), .lockOwner(lockOwner), .busy(busy), .protoErr(protoErr),
    .dbgState(dbgState), .dbgStarveCnt(dbgStarveCnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // memory and its shadow copy in the model
  logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    memDout <= mem[memAddr];
    if (memWe) mem[memAddr] = memDin;
  end

  // reference model
  logic m_eb_ack, m_fe_ack, m_we, m_eb_rv, m_fe_rv, m_lock_v, m_lock_o, m_perr, m_rd_port;
  logic [ADDR_W-1:0] m_addr, m_rd_addr;
  logic [DATA_W-1:0] m_din, m_eb_rd, m_fe_rd;
  int m_busy_left, m_rd_cnt, m_starve;

  always @(posedge clk or negedge rst_n) begin : ref_model
    bit eb_ok, fe_ok, fe_pend, g_any, g_fe, g_rd, g_pse;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    if (!rst_n) begin
      m_eb_ack = 0; m_fe_ack = 0; m_we = 0; m_eb_rv = 0; m_fe_rv = 0;
      m_lock_v = 0; m_lock_o = 0; m_perr = 0; m_rd_port = 0;
      m_addr = '0; m_rd_addr = '0; m_din = '0; m_eb_rd = '0; m_fe_rd = '0;
      m_busy_left = 0; m_rd_cnt = 0; m_starve = 0;
    end else begin
      m_eb_ack = 0; m_fe_ack = 0; m_we = 0; m_eb_rv = 0; m_fe_rv = 0;
      if ((ebReq && ebRead == ebWrite) || (feReq && feRead == feWrite)) m_perr = 1;
      if (m_rd_cnt > 0) begin
        m_rd_cnt--;
        if (m_rd_cnt == 0) begin
          if (m_rd_port) begin m_fe_rd = shadow[m_rd_addr]; m_fe_rv = 1; end
          else begin m_eb_rd = shadow[m_rd_addr]; m_eb_rv = 1; end
        end
      end
      if (m_busy_left > 0) begin
        m_busy_left--;
      end else begin
        eb_ok   = ebReq && (ebRead != ebWrite) && (!m_lock_v || m_lock_o == 0);
        fe_ok   = feReq && (feRead != feWrite) && (!m_lock_v || m_lock_o == 1);
        fe_pend = feReq && (feRead != feWrite);
        g_any = 0; g_fe = 0;
        if (fe_ok && (!eb_ok || m_starve == STARVE_MAX)) begin g_any = 1; g_fe = 1; end
        else if (eb_ok) g_any = 1;
        if (!feReq || (g_any && g_fe)) m_starve = 0;
        else if (g_any && fe_pend && m_starve < STARVE_MAX) m_starve++;
        if (g_any) begin
          g_rd   = g_fe ? feRead : ebRead;
          g_pse  = g_fe ? fePSE : ebPSE;
          g_addr = g_fe ? feAddr : ebAddr;
          g_data = g_fe ? feWData : ebWData;
          if (g_fe) m_fe_ack = 1; else m_eb_ack = 1;
          m_addr = g_addr;
          m_din  = g_rd ? '0 : g_data;
          m_we   = !g_rd;
          m_busy_left = g_rd ? 2 : 1;
          if (g_rd) begin
            m_rd_cnt = 2; m_rd_port = g_fe; m_rd_addr = g_addr;
            if (g_pse) begin m_lock_v = 1; m_lock_o = g_fe; end
          end else begin
            shadow[g_addr] = g_data;
            if (m_lock_v && m_lock_o == g_fe) m_lock_v = 0;
          end
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ebAck",     64'(ebAck),     64'(m_eb_ack));
      chk("feAck",     64'(feAck),     64'(m_fe_ack));
      chk("ebRValid",  64'(ebRValid),  64'(m_eb_rv));
      chk("feRValid",  64'(feRValid),  64'(m_fe_rv));
      chk("ebRData",   64'(ebRData),   64'(m_eb_rd));
      chk("feRData",   64'(feRData),   64'(m_fe_rd));
      chk("memWe",     64'(memWe),     64'(m_we));
      chk("memAddr",   64'(memAddr),   64'(m_addr));
      chk("memDin",    64'(memDin),    64'(m_din));
      chk("lockValid", 64'(lockValid), 64'(m_lock_v));
      chk("lockOwner", 64'(lockOwner), 64'(m_lock_o));
      chk("busy",      64'(busy),      64'(m_busy_left != 0));
      chk("protoErr",  64'(protoErr),  64'(m_perr));
      chk("starveCnt", 64'(dbgStarveCnt), 64'(m_starve));
    end
  end

  // grant-order scoreboard: 0 = EBOX, 1 = FE
  logic [0:0] exp_q[$];
  logic [0:0] gnt_log[$];
  always @(negedge clk) begin
    if (ebAck === 1'b1) gnt_log.push_back(1'b0);
    if (feAck === 1'b1) gnt_log.push_back(1'b1);
  end

  // driver tasks / processes
  cmd_t eb_q[$], fe_q[$];
  bit eb_act, fe_act;
  int eb_hold, fe_hold, eb_wait, fe_wait;

  function automatic cmd_t mk(input logic rd, input logic wr, input logic pse,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int gap);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.pse = pse; c.addr = a; c.data = d; c.gap = gap;
    return c;
  endfunction

  always @(negedge clk or negedge rst_n) begin : eb_drv
    cmd_t c;
    if (!rst_n) begin
      eb_act = 0; eb_hold = 0; eb_wait = 0; ebReq = 0;
    end else begin
      if (eb_act) begin
        eb_hold++;
        // an illegal request is never acked, so it is withdrawn after a while
        if (ebAck || (ebRead == ebWrite && eb_hold > 12)) begin eb_act = 0; ebReq = 0; end
      end
      if (!eb_act && eb_q.size() > 0) begin
        if (eb_wait < eb_q[0].gap) eb_wait++;
        else begin
          c = eb_q.pop_front();
          ebRead = c.rd; ebWrite = c.wr; ebPSE = c.pse; ebAddr = c.addr; ebWData = c.data;
          ebReq = 1; eb_act = 1; eb_hold = 0; eb_wait = 0;
        end
      end
    end
  end

  always @(negedge clk or negedge rst_n) begin : fe_drv
    cmd_t c;
    if (!rst_n) begin
      fe_act = 0; fe_hold = 0; fe_wait = 0; feReq = 0;
    end else begin
      if (fe_act) begin
        fe_hold++;
        if (feAck || (feRead == feWrite && fe_hold > 12)) begin fe_act = 0; feReq = 0; end
      end
      if (!fe_act && fe_q.size() > 0) begin
        if (fe_wait < fe_q[0].gap) fe_wait++;
        else begin
          c = fe_q.pop_front();
          feRead = c.rd; feWrite = c.wr; fePSE = c.pse; feAddr = c.addr; feWData = c.data;
          feReq = 1; fe_act = 1; fe_hold = 0; fe_wait = 0;
        end
      end
    end
  end

  task automatic wait_idle(input string tag, input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      done = (eb_q.size() == 0) && (fe_q.size() == 0) && !eb_act && !fe_act &&
             (m_busy_left == 0) && (m_rd_cnt == 0);
    end
    repeat (2) @(negedge clk);
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic check_grants(input string tag);
    chk({tag, "_count"}, 64'(gnt_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++)
      chk({tag, "_order"}, 64'(gnt_log[i]), 64'(exp_q[i]));
  endtask

  task automatic start_phase();
    @(posedge clk);
    gnt_log.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      v = DATA_W'({$urandom(), $urandom()});
      mem[i] = v;
      shadow[i] = v;
    end
    repeat (2) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    #2 rst_n = 1;

    // EBOX write then read back
    start_phase();
    eb_q.push_back(mk(0, 1, 0, 12'h005, 36'o123456701234, 0));
    eb_q.push_back(mk(1, 0, 0, 12'h005, '0, 2));
    wait_idle("t1_drain", 200);
    chk("t1_rdata", 64'(ebRData), 64'(36'o123456701234));

    // both ports streaming reads: EB x4 then FE
    start_phase();
    for (int i = 0; i < 12; i++) eb_q.push_back(mk(1, 0, 0, 12'($urandom_range(0, 63)), '0, 0));
    for (int i = 0; i < 3; i++)  fe_q.push_back(mk(1, 0, 0, 12'($urandom_range(0, 63)), '0, 0));
    for (int k = 0; k < 3; k++) begin
      repeat (STARVE_MAX) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    wait_idle("t2_drain", 500);
    check_grants("t2_starve");

    // FE PSE lock blocks EBOX until the FE write
    start_phase();
    fe_q.push_back(mk(1, 0, 1, 12'h010, '0, 0));
    fe_q.push_back(mk(0, 1, 0, 12'h010, 36'h1234_5678A, 6));
    eb_q.push_back(mk(1, 0, 0, 12'h020, '0, 2));
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    wait_idle("t3_drain", 300);
    check_grants("t3_felock");

    // EBOX lock outlasts starvation limit
    start_phase();
    eb_q.push_back(mk(1, 0, 1, 12'h030, '0, 0));
    for (int i = 0; i < 6; i++) eb_q.push_back(mk(1, 0, (i == 2), 12'($urandom_range(0, 63)), '0, 0));
    eb_q.push_back(mk(0, 1, 1, 12'h030, 36'hF_0F0F_0F0F, 0));
    fe_q.push_back(mk(1, 0, 0, 12'h040, '0, 0));
    repeat (8) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    wait_idle("t4_drain", 300);
    check_grants("t4_eblock");

    // illegal EBOX request: protoErr, no ack, FE still served
    start_phase();
    eb_q.push_back(mk(1, 1, 0, 12'h060, '0, 0));
    for (int i = 0; i < 3; i++) fe_q.push_back(mk(i[0], !i[0], 0, 12'h061, 36'($urandom()), 0));
    repeat (3) exp_q.push_back(1'b1);
    wait_idle("t5_drain", 300);
    check_grants("t5_illegal");
    chk("t5_protoErr", 64'(protoErr), 64'd1);

    // reset while an FE PSE read is in RDATA
    begin
      bit seen = 0;
      start_phase();
      fe_q.push_back(mk(1, 0, 1, 12'h050, '0, 0));
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = (feAck === 1'b1);
      end
      chk("t6_ack_seen", 64'(seen), 64'd1);
      @(negedge clk);
      #2 rst_n = 0;
      @(negedge clk);
      chk("t6_feRValid", 64'(feRValid), 64'd0);
      chk("t6_lockValid", 64'(lockValid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_protoErr", 64'(protoErr), 64'd0);
      chk("t6_feRData", 64'(feRData), 64'd0);
      @(negedge clk);
      chk("t6_no_rvalid", 64'(feRValid), 64'd0);
      #2 rst_n = 1;
    end

    // random traffic on both ports
    start_phase();
    for (int i = 0; i < 120; i++) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      eb_q.push_back(mk(r, !r, ($urandom_range(0, 3) == 0), 12'($urandom_range(0, 15)),
                        DATA_W'({$urandom(), $urandom()}),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
      r = 1'($urandom_range(0, 1));
      fe_q.push_back(mk(r, !r, ($urandom_range(0, 3) == 0), 12'($urandom_range(0, 15)),
                        DATA_W'({$urandom(), $urandom()}),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
    end
    eb_q.push_back(mk(0, 1, 0, 12'h00A, 36'h5_5555_5555, 0));
    fe_q.push_back(mk(0, 1, 0, 12'h00B, 36'hA_AAAA_AAAA, 0));
    wait_idle("t7_drain", 20000);
    chk("t7_unlocked", 64'(lockValid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
